// File: rtl/irq_prio_ctrl.sv
// Registered interrupt-priority controller: latches NBUS x NCH requests, masks per channel,
// picks a fixed-priority winner and holds it on a valid/ack handshake until accepted.
module irq_prio_ctrl #(
  parameter int unsigned NBUS = 3,
  parameter int unsigned NCH  = 9,
  parameter int unsigned EDGE = 0,
  parameter int unsigned CW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBUS*NCH-1:0]  irq_in,
  input  logic [NCH-1:0]       irq_en,
  input  logic                 ack,
  output logic                 valid,
  output logic [NBUS-1:0]      bus_sel,
  output logic [CW-1:0]        chan_idx,
  output logic [NBUS*NCH-1:0]  pend
);

  localparam int unsigned NIRQ = NBUS * NCH;

  typedef enum logic {
    S_IDLE,
    S_PRESENT
  } state_t;

  state_t            r_state;
  logic              r_valid;
  logic [NBUS-1:0]   r_bus_sel;
  logic [CW-1:0]     r_chan_idx;
  logic [NIRQ-1:0]   r_pend;
  logic [NIRQ-1:0]   r_prev;
  logic              r_armed;

  state_t            w_state_nxt;
  logic              w_valid_nxt;
  logic [NBUS-1:0]   w_bus_sel_nxt;
  logic [CW-1:0]     w_chan_idx_nxt;
  logic [NIRQ-1:0]   w_pend_nxt;
  logic [NIRQ-1:0]   w_elig;
  logic [NIRQ-1:0]   w_ack_mask;
  logic [NIRQ-1:0]   w_clr;
  logic [NIRQ-1:0]   w_rise;
  logic              w_found;
  logic [NBUS-1:0]   w_win_sel;
  logic [CW-1:0]     w_win_chan;

  // Eligibility, fixed-priority winner (lowest bus, then lowest channel) and the winner's pend bit
  always_comb begin
    w_elig     = '0;
    w_ack_mask = '0;
    w_found    = 1'b0;
    w_win_sel  = '0;
    w_win_chan = '0;
    for (int b = 0; b < NBUS; b++) begin
      w_elig[b*NCH +: NCH] = r_pend[b*NCH +: NCH] & irq_en;
    end
    for (int b = 0; b < NBUS; b++) begin
      for (int c = 0; c < NCH; c++) begin
        w_ack_mask[b*NCH+c] = r_bus_sel[b] && (r_chan_idx == CW'(c));
        if (!w_found && w_elig[b*NCH+c]) begin
          w_found       = 1'b1;
          w_win_sel[b]  = 1'b1;
          w_win_chan    = CW'(c);
        end
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = r_valid;
    w_bus_sel_nxt  = r_bus_sel;
    w_chan_idx_nxt = r_chan_idx;
    w_clr          = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_PRESENT;
          w_valid_nxt    = 1'b1;
          w_bus_sel_nxt  = w_win_sel;
          w_chan_idx_nxt = w_win_chan;
        end else begin
          w_valid_nxt    = 1'b0;
          w_bus_sel_nxt  = '0;
          w_chan_idx_nxt = '0;
        end
      end
      S_PRESENT: begin
        if (ack) begin
          w_state_nxt    = S_IDLE;
          w_valid_nxt    = 1'b0;
          w_bus_sel_nxt  = '0;
          w_chan_idx_nxt = '0;
          if (EDGE != 0) begin
            w_clr = w_ack_mask;
          end
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_valid_nxt    = 1'b0;
        w_bus_sel_nxt  = '0;
        w_chan_idx_nxt = '0;
      end
    endcase
  end

  // r_armed masks the first post-reset cycle so a request held through reset is not seen as an edge
  assign w_rise     = irq_in & ~r_prev & {NIRQ{r_armed}};
  assign w_pend_nxt = (EDGE != 0) ? ((r_pend & ~w_clr) | w_rise) : irq_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_bus_sel  <= '0;
      r_chan_idx <= '0;
      r_pend     <= '0;
      r_prev     <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_bus_sel  <= w_bus_sel_nxt;
      r_chan_idx <= w_chan_idx_nxt;
      r_pend     <= w_pend_nxt;
      r_prev     <= irq_in;
      r_armed    <= 1'b1;
    end
  end

  assign valid    = r_valid;
  assign bus_sel  = r_bus_sel;
  assign chan_idx = r_chan_idx;
  assign pend     = r_pend;

endmodule
